// File: rtl/way_alloc_unit.sv
// way_alloc_unit: per-set valid bits and true-LRU ages for the set-associative L2.
// Answers ALLOC / TOUCH / INVAL / QUERY requests and runs a flush sweep.
// Optional build macro: WAY_ALLOC_STATS_EN adds saturating stat_alloc, stat_evict
// and stat_inval counters.
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready.
// req_ready is combinational and is low during reset, during a flush sweep, and
// in the cycle clr_start is high. The state update commits on the accept edge.
// The response is registered, and rsp_valid pulses for one cycle after the accept.
module way_alloc_unit #(
  parameter int WAYS = 8,
  parameter int SETS = 64,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [IDX_W-1:0] req_index,
  input  logic [WAY_W-1:0] req_way,
  output logic             rsp_valid,
  output logic [WAY_W-1:0] rsp_way,
  output logic             rsp_evict,
  output logic             rsp_full,
  input  logic             clr_start,
  output logic             clr_busy,
`ifdef WAY_ALLOC_STATS_EN
  output logic [31:0]      stat_alloc,
  output logic [31:0]      stat_evict,
  output logic [31:0]      stat_inval,
`endif
  output logic             fsm_state
);

  localparam logic [1:0] OP_ALLOC = 2'b00;
  localparam logic [1:0] OP_TOUCH = 2'b01;
  localparam logic [1:0] OP_INVAL = 2'b10;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;
  typedef logic [WAYS-1:0][WAY_W-1:0] age_vec_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  logic [WAYS-1:0]  valid_q [SETS];
  age_vec_t         age_q [SETS];

  logic             accept;
  logic [WAYS-1:0]  cur_valid, nxt_valid;
  age_vec_t         cur_age, nxt_age;
  logic             empty_found, set_wr;
  logic [WAY_W-1:0] empty_way, lru_way, alloc_way;
  logic [WAY_W-1:0] rsp_way_d;
  logic             rsp_evict_d, rsp_full_d;

  // Way w moves to age 0; every way younger than its old age gets one step older.
  function automatic age_vec_t touch_ages(input age_vec_t a, input logic [WAY_W-1:0] w);
    age_vec_t r;
    logic [WAY_W-1:0] old;
    old = a[w];
    r = a;
    for (int i = 0; i < WAYS; i++) begin
      if (WAY_W'(i) == w) r[i] = '0;
      else if (a[i] < old) r[i] = a[i] + WAY_W'(1);
    end
    return r;
  endfunction

  // Way w moves to LRU; every way older than its old age gets one step younger.
  function automatic age_vec_t inval_ages(input age_vec_t a, input logic [WAY_W-1:0] w);
    age_vec_t r;
    logic [WAY_W-1:0] old;
    old = a[w];
    r = a;
    for (int i = 0; i < WAYS; i++) begin
      if (WAY_W'(i) == w) r[i] = WAY_W'(WAYS - 1);
      else if (a[i] > old) r[i] = a[i] - WAY_W'(1);
    end
    return r;
  endfunction

  function automatic age_vec_t init_ages();
    age_vec_t r;
    for (int i = 0; i < WAYS; i++) r[i] = WAY_W'(i);
    return r;
  endfunction

  assign req_ready = (state_q == S_IDLE) && !clr_start && !rst;
  assign accept    = req_valid && req_ready;
  assign clr_busy  = (state_q == S_CLEAR);
  assign fsm_state = state_q;

  // FSM state and sweep index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state logic: IDLE waits for clr_start, CLEAR walks every set once.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d   = S_CLEAR;
          clr_idx_d = '0;
        end
      end
      S_CLEAR: begin
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request decode: empty/LRU search on the addressed set and its updated contents.
  always_comb begin
    cur_valid   = valid_q[req_index];
    cur_age     = age_q[req_index];
    empty_found = 1'b0;
    empty_way   = '0;
    lru_way     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!cur_valid[w]) begin
        empty_found = 1'b1;
        empty_way   = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (cur_age[w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    alloc_way   = empty_found ? empty_way : lru_way;
    nxt_valid   = cur_valid;
    nxt_age     = cur_age;
    set_wr      = 1'b0;
    rsp_way_d   = req_way;
    rsp_evict_d = 1'b0;
    rsp_full_d  = 1'b0;
    case (req_op)
      OP_ALLOC: begin
        rsp_way_d            = alloc_way;
        rsp_evict_d          = !empty_found;
        rsp_full_d           = !empty_found;
        nxt_valid[alloc_way] = 1'b1;
        nxt_age              = touch_ages(cur_age, alloc_way);
        set_wr               = 1'b1;
      end
      OP_TOUCH: begin
        nxt_age = touch_ages(cur_age, req_way);
        set_wr  = 1'b1;
      end
      OP_INVAL: begin
        nxt_valid[req_way] = 1'b0;
        nxt_age            = inval_ages(cur_age, req_way);
        set_wr             = 1'b1;
      end
      default: begin
        rsp_way_d  = empty_found ? empty_way : '0;
        rsp_full_d = !empty_found;
      end
    endcase
  end

  // Set storage: reset/sweep restore the empty, identity-aged state; accepts commit updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= init_ages();
      end
    end else if (state_q == S_CLEAR) begin
      valid_q[clr_idx_q] <= '0;
      age_q[clr_idx_q]   <= init_ages();
    end else if (accept && set_wr) begin
      valid_q[req_index] <= nxt_valid;
      age_q[req_index]   <= nxt_age;
    end
  end

  // Registered one-cycle response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_way   <= '0;
      rsp_evict <= 1'b0;
      rsp_full  <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_way   <= rsp_way_d;
        rsp_evict <= rsp_evict_d;
        rsp_full  <= rsp_full_d;
      end
    end
  end

`ifdef WAY_ALLOC_STATS_EN
  // Saturating operation counters, cleared by reset and by a flush start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_alloc <= '0;
      stat_evict <= '0;
      stat_inval <= '0;
    end else if (clr_start && state_q == S_IDLE) begin
      stat_alloc <= '0;
      stat_evict <= '0;
      stat_inval <= '0;
    end else if (accept) begin
      if (req_op == OP_ALLOC && stat_alloc != 32'hFFFF_FFFF)
        stat_alloc <= stat_alloc + 32'd1;
      if (req_op == OP_ALLOC && !empty_found && stat_evict != 32'hFFFF_FFFF)
        stat_evict <= stat_evict + 32'd1;
      if (req_op == OP_INVAL && stat_inval != 32'hFFFF_FFFF)
        stat_inval <= stat_inval + 32'd1;
    end
  end
`endif

endmodule
